free_address_pool: RTL and testbench



---
 rtl/free_address_pool.sv | 165 ++++++++++++++++
 tb/tb_free_address_pool.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/free_address_pool.sv
// free_address_pool
// -----------------
// Free-list manager for the shared cell buffer. A circular list of free cell
// addresses is seeded with 0..bufferAddresses-1 after reset. The head of the
// list is offered to the write arbiter, and freed addresses are appended at the
// tail. A per-address in-use bitmap catches double allocation and double
// release.
//
// Ports
//   clk             single clock
//   rstn            synchronous active-low reset
//   wroteCell       arbiter committed a cell at writeAddress this cycle
//   releaseValid    releaseAddress is returned to the pool this cycle
//   releaseAddress  address being freed
//   errorClear      clears the sticky error flags
//   writeAddress    head of the free list (valid while writeRejected=0)
//   writeRejected   no address available (empty pool or still initialising)
//   ready           initialisation complete
//   freeCount       number of free addresses
//   almostEmpty     freeCount <= almostEmptyLevel
//   allocError      sticky: wroteCell while rejected, or head already in use
//   releaseError    sticky: release of an address not currently in use
module free_address_pool #(
    parameter int unsigned bufferAddresses  = 32,
    parameter int unsigned addressWidth     = $clog2(bufferAddresses),
    parameter int unsigned almostEmptyLevel = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wroteCell,
    input  logic                    releaseValid,
    input  logic [addressWidth-1:0] releaseAddress,
    input  logic                    errorClear,
    output logic [addressWidth-1:0] writeAddress,
    output logic                    writeRejected,
    output logic                    ready,
    output logic [addressWidth:0]   freeCount,
    output logic                    almostEmpty,
    output logic                    allocError,
    output logic                    releaseError
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam logic [addressWidth-1:0] LAST = addressWidth'(bufferAddresses - 1);
    localparam logic [addressWidth:0]   FULL = (addressWidth + 1)'(bufferAddresses);

    // Pointers wrap on an explicit compare so non-power-of-two sizes work.
    function automatic logic [addressWidth-1:0] nextPtr(input logic [addressWidth-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    state_t                    state_q;
    logic [addressWidth-1:0]   list_q [bufferAddresses];
    logic [addressWidth-1:0]   initPtr_q;
    logic [addressWidth-1:0]   rdPtr_q;
    logic [addressWidth-1:0]   wrPtr_q;
    logic [bufferAddresses-1:0] inUse_q;
    logic [bufferAddresses-1:0] inUse_d;
    logic [addressWidth:0]     freeCount_q;
    logic [addressWidth:0]     freeCount_d;
    logic                      almostEmpty_q;
    logic                      allocError_q;
    logic                      releaseError_q;

    logic [addressWidth-1:0]   headAddr;
    logic                      rejected;
    logic                      relInUse;
    logic                      doAlloc;
    logic                      doRelease;
    logic                      allocBad;
    logic                      releaseBad;

    always_comb begin
        headAddr = list_q[rdPtr_q];
        rejected = (state_q != READY) || (freeCount_q == '0);

        // Out-of-range addresses have no bitmap entry and count as not in use.
        relInUse = 1'b0;
        if (32'(releaseAddress) < bufferAddresses) begin
            relInUse = inUse_q[releaseAddress];
        end

        doAlloc    = wroteCell && !rejected;
        // Releasing the address being allocated in the same cycle is treated
        // as a release of a free address: dropped, allocate still proceeds.
        doRelease  = releaseValid && (state_q == READY) && relInUse &&
                     !(doAlloc && (releaseAddress == headAddr));
        allocBad   = wroteCell && (rejected || inUse_q[headAddr]);
        releaseBad = releaseValid && !doRelease;

        freeCount_d = freeCount_q;
        if (doAlloc && !doRelease) begin
            freeCount_d = freeCount_q - 1'b1;
        end else if (doRelease && !doAlloc) begin
            freeCount_d = freeCount_q + 1'b1;
        end

        inUse_d = inUse_q;
        if (doRelease) begin
            inUse_d[releaseAddress] = 1'b0;
        end
        if (doAlloc) begin
            inUse_d[headAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= INIT;
            initPtr_q      <= '0;
            rdPtr_q        <= '0;
            wrPtr_q        <= '0;
            inUse_q        <= '0;
            freeCount_q    <= '0;
            almostEmpty_q  <= 1'b1;
            allocError_q   <= 1'b0;
            releaseError_q <= 1'b0;
        end else begin
            // A new error in the same cycle as errorClear keeps the flag set.
            allocError_q   <= allocBad || (allocError_q && !errorClear);
            releaseError_q <= releaseBad || (releaseError_q && !errorClear);

            case (state_q)
                INIT: begin
                    list_q[initPtr_q] <= initPtr_q;
                    if (initPtr_q == LAST) begin
                        state_q       <= READY;
                        rdPtr_q       <= '0;
                        wrPtr_q       <= '0;
                        freeCount_q   <= FULL;
                        almostEmpty_q <= (bufferAddresses <= almostEmptyLevel);
                    end else begin
                        initPtr_q <= initPtr_q + 1'b1;
                    end
                end
                READY: begin
                    if (doAlloc) begin
                        rdPtr_q <= nextPtr(rdPtr_q);
                    end
                    if (doRelease) begin
                        list_q[wrPtr_q] <= releaseAddress;
                        wrPtr_q         <= nextPtr(wrPtr_q);
                    end
                    inUse_q       <= inUse_d;
                    freeCount_q   <= freeCount_d;
                    almostEmpty_q <= (32'(freeCount_d) <= almostEmptyLevel);
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign ready         = (state_q == READY);
    assign writeAddress  = ready ? headAddr : '0;
    assign writeRejected = rejected;
    assign freeCount     = freeCount_q;
    assign almostEmpty   = almostEmpty_q;
    assign allocError    = allocError_q;
    assign releaseError  = releaseError_q;

endmodule

// File: tb/tb_free_address_pool.sv
// Directed bench for free_address_pool: a 32-entry instance (A) and a
// 24-entry instance (B). Inputs change on the falling edge; outputs are
// checked on the following falling edge.
module tb_free_address_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: 32 addresses
    logic       a_rstn, a_wc, a_rv, a_ec;
    logic [4:0] a_ra, a_wa;
    logic       a_rej, a_rdy, a_ae, a_aerr, a_rerr;
    logic [5:0] a_fc;

    // Instance B: 24 addresses
    logic       b_rstn, b_wc, b_rv, b_ec;
    logic [4:0] b_ra, b_wa;
    logic       b_rej, b_rdy, b_ae, b_aerr, b_rerr;
    logic [5:0] b_fc;

    free_address_pool #(.bufferAddresses(32), .almostEmptyLevel(4)) dut_a (
        .clk(clk), .rstn(a_rstn), .wroteCell(a_wc), .releaseValid(a_rv),
        .releaseAddress(a_ra), .errorClear(a_ec), .writeAddress(a_wa),
        .writeRejected(a_rej), .ready(a_rdy), .freeCount(a_fc),
        .almostEmpty(a_ae), .allocError(a_aerr), .releaseError(a_rerr)
    );

    free_address_pool #(.bufferAddresses(24), .almostEmptyLevel(4)) dut_b (
        .clk(clk), .rstn(b_rstn), .wroteCell(b_wc), .releaseValid(b_rv),
        .releaseAddress(b_ra), .errorClear(b_ec), .writeAddress(b_wa),
        .writeRejected(b_rej), .ready(b_rdy), .freeCount(b_fc),
        .almostEmpty(b_ae), .allocError(b_aerr), .releaseError(b_rerr)
    );

    typedef struct {
        logic       wc;
        logic       rv;
        logic [4:0] ra;
        logic       ec;
        logic       chk_wa;
        logic [4:0] wa;
        logic       rej;
        logic [5:0] fc;
        logic       ae;
        logic       aerr;
        logic       rerr;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_rej;

        // wc rv ra ec | chk_wa wa rej fc ae aerr rerr
        tbl[0]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 5'd3, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 5'd3, 1'b0, 6'd2, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 6'd2, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0};

        a_rstn = 1'b0; a_wc = 1'b0; a_rv = 1'b0; a_ra = '0; a_ec = 1'b0;
        b_rstn = 1'b0; b_wc = 1'b0; b_rv = 1'b0; b_ra = '0; b_ec = 1'b0;
        @(negedge clk);
        tick;

        // ---------------- Instance A: reset values ----------------
        chk("A reset writeAddress", a_wa, 0);
        chk("A reset writeRejected", a_rej, 1);
        chk("A reset ready", a_rdy, 0);
        chk("A reset freeCount", a_fc, 0);
        chk("A reset almostEmpty", a_ae, 1);
        chk("A reset allocError", a_aerr, 0);
        chk("A reset releaseError", a_rerr, 0);

        // INIT takes exactly 32 cycles
        a_rstn = 1'b1;
        for (int i = 0; i < 31; i++) tick;
        chk("A ready after 31", a_rdy, 0);
        chk("A rejected after 31", a_rej, 1);
        tick;
        chk("A ready after 32", a_rdy, 1);
        chk("A rejected after 32", a_rej, 0);
        chk("A freeCount after init", a_fc, 32);
        chk("A writeAddress after init", a_wa, 0);
        chk("A almostEmpty after init", a_ae, 0);

        // Drain: 32 accepts then one rejected write
        a_wc = 1'b1;
        for (int k = 0; k < 33; k++) begin
            if (k < 32) chk($sformatf("A drain writeAddress %0d", k), a_wa, k);
            tick;
            if (k < 32) begin
                chk($sformatf("A drain freeCount %0d", k), a_fc, 31 - k);
                chk($sformatf("A drain almostEmpty %0d", k), a_ae, (31 - k) <= 4 ? 1 : 0);
                chk($sformatf("A drain allocError %0d", k), a_aerr, 0);
            end
        end
        chk("A empty rejected", a_rej, 1);
        chk("A empty freeCount", a_fc, 0);
        chk("A 33rd write allocError", a_aerr, 1);
        a_wc = 1'b0;

        // Table: release order, double release, errorClear, same-cycle cases
        prev_rej = 1'b1;
        for (int i = 0; i < 13; i++) begin
            a_wc = tbl[i].wc; a_rv = tbl[i].rv; a_ra = tbl[i].ra; a_ec = tbl[i].ec;
            #1;
            chk($sformatf("A vec%0d rejected before edge", i), a_rej, prev_rej);
            tick;
            if (tbl[i].chk_wa) chk($sformatf("A vec%0d writeAddress", i), a_wa, tbl[i].wa);
            chk($sformatf("A vec%0d writeRejected", i), a_rej, tbl[i].rej);
            chk($sformatf("A vec%0d freeCount", i), a_fc, tbl[i].fc);
            chk($sformatf("A vec%0d almostEmpty", i), a_ae, tbl[i].ae);
            chk($sformatf("A vec%0d allocError", i), a_aerr, tbl[i].aerr);
            chk($sformatf("A vec%0d releaseError", i), a_rerr, tbl[i].rerr);
            prev_rej = tbl[i].rej;
        end
        a_wc = 1'b0; a_rv = 1'b0; a_ec = 1'b0;

        // ---------------- Instance B: 24 addresses ----------------
        b_rstn = 1'b1;
        for (int i = 0; i < 23; i++) tick;
        chk("B ready after 23", b_rdy, 0);
        tick;
        chk("B ready after 24", b_rdy, 1);
        chk("B freeCount after init", b_fc, 24);
        chk("B writeAddress after init", b_wa, 0);

        b_wc = 1'b1;
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("B alloc1 writeAddress %0d", k), b_wa, k);
            tick;
        end
        b_wc = 1'b0;
        chk("B empty freeCount", b_fc, 0);
        chk("B empty rejected", b_rej, 1);

        b_rv = 1'b1;
        for (int k = 0; k < 24; k++) begin
            b_ra = 5'(k);
            tick;
            chk($sformatf("B release freeCount %0d", k), b_fc, k + 1);
        end
        chk("B full releaseError", b_rerr, 0);
        b_ra = 5'd30;
        tick;
        chk("B out-of-range releaseError", b_rerr, 1);
        chk("B out-of-range freeCount", b_fc, 24);
        b_rv = 1'b0;

        b_wc = 1'b1;
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("B alloc2 writeAddress %0d", k), b_wa, k);
            tick;
        end
        b_wc = 1'b0;
        chk("B alloc2 freeCount", b_fc, 0);
        b_rv = 1'b1; b_ra = 5'd5;
        tick;
        b_rv = 1'b0;
        chk("B release 5 freeCount", b_fc, 1);
        chk("B release 5 writeAddress", b_wa, 5);

        // Reset in the middle of traffic
        b_wc = 1'b1; b_rstn = 1'b0;
        tick;
        chk("B midreset freeCount", b_fc, 0);
        chk("B midreset ready", b_rdy, 0);
        chk("B midreset rejected", b_rej, 1);
        chk("B midreset releaseError", b_rerr, 0);

        b_rstn = 1'b1; b_wc = 1'b1; b_rv = 1'b1; b_ra = 5'd3;
        tick;
        b_wc = 1'b0; b_rv = 1'b0;
        chk("B init releaseError", b_rerr, 1);
        chk("B init allocError", b_aerr, 1);
        chk("B init ready", b_rdy, 0);
        for (int i = 0; i < 22; i++) tick;
        chk("B reinit ready after 23", b_rdy, 0);
        tick;
        chk("B reinit ready after 24", b_rdy, 1);
        chk("B reinit freeCount", b_fc, 24);
        chk("B reinit writeAddress", b_wa, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
